// File: rtl/loopback_ctrl.sv
// Loopback test sequencer: resets the checker, waits for a stable latency,
// runs a bounded-length bit test and reports pass/fail and the error count.
module loopback_ctrl #(
    parameter int unsigned n_addr        = 8,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_CYCLES   = 32,
    parameter int unsigned ALIGN_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [63:0]       test_len,
    input  logic [63:0]       max_err,
    input  logic [63:0]       correct_bits,
    input  logic [63:0]       total_bits,
    input  logic [n_addr-1:0] latency,
    output logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [63:0]       err_bits,
    output logic [n_addr-1:0] lock_latency
);

    localparam int unsigned CNT_MAX_V = (ALIGN_TIMEOUT > RESET_CYCLES) ? ALIGN_TIMEOUT : RESET_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX_V + 1);
    localparam int unsigned STAB_W    = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] MODE_RESET = 2'b00;
    localparam logic [1:0] MODE_ALIGN = 2'b01;
    localparam logic [1:0] MODE_TEST  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_ALIGN,
        S_TEST,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic [n_addr-1:0]   prev_lat_q;
    logic [63:0]         test_len_q, test_len_d;
    logic [63:0]         max_err_q, max_err_d;
    logic                pass_d, timeout_d, busy_d, done_d;
    logic [63:0]         err_bits_d;
    logic [n_addr-1:0]   lock_latency_d;
    logic [1:0]          mode_d;
    logic [63:0]         diff_c;

    assign diff_c = total_bits - correct_bits;

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stab_d         = stab_q;
        test_len_d     = test_len_q;
        max_err_d      = max_err_q;
        pass_d         = pass;
        timeout_d      = timeout;
        err_bits_d     = err_bits;
        lock_latency_d = lock_latency;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    test_len_d = test_len;
                    max_err_d  = max_err;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    err_bits_d = 64'd0;
                    cnt_d      = '0;
                    state_d    = S_RST;
                end
            end
            S_RST: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    stab_d  = '0;
                    state_d = S_ALIGN;
                end else if (cnt_q != CNT_W'(CNT_MAX_V)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ALIGN: begin
                if (cnt_q != CNT_W'(CNT_MAX_V)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (latency != prev_lat_q) begin
                    stab_d = '0;
                end else if (stab_q != STAB_W'(LOCK_CYCLES)) begin
                    stab_d = stab_q + STAB_W'(1);
                end
                // Priority: abort, then lock, then timeout.
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (stab_q == STAB_W'(LOCK_CYCLES - 1)) begin
                    lock_latency_d = latency;
                    state_d        = S_TEST;
                end else if (cnt_q == CNT_W'(ALIGN_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_FINISH;
                end
            end
            S_TEST: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (total_bits >= test_len_q) begin
                    err_bits_d = diff_c;
                    pass_d     = (diff_c <= max_err_q);
                    state_d    = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_ALIGN: mode_d = MODE_ALIGN;
            S_TEST:  mode_d = MODE_TEST;
            default: mode_d = MODE_RESET;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stab_q       <= '0;
            prev_lat_q   <= '0;
            test_len_q   <= 64'd0;
            max_err_q    <= 64'd0;
            mode         <= MODE_RESET;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            err_bits     <= 64'd0;
            lock_latency <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            prev_lat_q   <= latency;
            test_len_q   <= test_len_d;
            max_err_q    <= max_err_d;
            mode         <= mode_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
            timeout      <= timeout_d;
            err_bits     <= err_bits_d;
            lock_latency <= lock_latency_d;
        end
    end

endmodule

// File: tb/tb_loopback_ctrl.sv
// Directed self-checking bench for loopback_ctrl with a result scoreboard.
module tb_loopback_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [63:0] test_len, max_err, correct_bits, total_bits;
    logic [7:0]  latency;
    logic [1:0]  mode;
    logic        busy, done, pass, timeout;
    logic [63:0] err_bits;
    logic [7:0]  lock_latency;

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic [63:0] err_bits;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   tog      = 1'b0;

    loopback_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .test_len(test_len), .max_err(max_err),
        .correct_bits(correct_bits), .total_bits(total_bits),
        .latency(latency), .mode(mode), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .err_bits(err_bits),
        .lock_latency(lock_latency)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) latency = (latency == 8'd5) ? 8'd6 : 8'd5;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [63:0] tl, input logic [63:0] me);
        test_len = tl;
        max_err  = me;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic count_mode(input logic [1:0] m, output int n);
        n = 0;
        while (mode === m && busy === 1'b1 && n < 5000) begin
            n++;
            tick();
        end
    endtask

    task automatic finish_test(input logic [63:0] errs);
        repeat (5) tick();
        total_bits   = 64'd1000;
        correct_bits = 64'd1000 - errs;
        tick();
        total_bits   = 64'd0;
        correct_bits = 64'd0;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        int   n = 0;
        while (done !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_pass"}, 64'(pass), 64'(e.pass));
            check({tag, "_timeout"}, 64'(timeout), 64'(e.timeout));
            check({tag, "_err_bits"}, err_bits, e.err_bits);
        end
        tick();
        check({tag, "_done_1cyc"}, 64'({done, busy, mode}), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, 64'(mode), 64'd0);
        check({tag, "_flags"}, 64'({busy, done, pass, timeout}), 64'd0);
        check({tag, "_err_bits"}, err_bits, 64'd0);
        check({tag, "_lock_lat"}, 64'(lock_latency), 64'd0);
    endtask

    initial begin
        int n;
        int done_seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        test_len = 64'd0; max_err = 64'd0;
        correct_bits = 64'd0; total_bits = 64'd0; latency = 8'd5;
        tick(); tick();
        rst = 1'b0;
        check_reset_vals("reset");

        // Clean link, with a start pulse (and test_len=0) ignored during TEST.
        sb.push_back('{pass: 1'b1, timeout: 1'b0, err_bits: 64'd0});
        start_run(64'd1000, 64'd0);
        count_mode(2'b00, n);
        check("clean_rst_cycles", 64'(n), 64'd16);
        count_mode(2'b01, n);
        check("clean_align_cycles", 64'(n), 64'd32);
        check("clean_mode_test", 64'(mode), 64'd2);
        check("clean_lock_lat", 64'(lock_latency), 64'd5);
        test_len = 64'd0; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        check("busy_start_ignored", 64'({busy, mode}), 64'd6);
        finish_test(64'd0);
        check_done("clean");

        // Four errors against max_err=3 fails; three passes.
        sb.push_back('{pass: 1'b0, timeout: 1'b0, err_bits: 64'd4});
        start_run(64'd1000, 64'd3);
        check("start_clears_pass", 64'(pass), 64'd0);
        count_mode(2'b00, n);
        count_mode(2'b01, n);
        finish_test(64'd4);
        check_done("err4");

        sb.push_back('{pass: 1'b1, timeout: 1'b0, err_bits: 64'd3});
        start_run(64'd1000, 64'd3);
        count_mode(2'b00, n);
        count_mode(2'b01, n);
        finish_test(64'd3);
        check_done("err3");

        // Latency toggling every cycle never locks.
        sb.push_back('{pass: 1'b0, timeout: 1'b1, err_bits: 64'd0});
        tog = 1'b1;
        start_run(64'd1000, 64'd0);
        count_mode(2'b00, n);
        count_mode(2'b01, n);
        check("timeout_align_cycles", 64'(n), 64'd4096);
        check_done("timeout");
        tog = 1'b0; latency = 8'd5;

        // Abort ten cycles into TEST.
        start_run(64'd1000, 64'd0);
        check("start_clears_timeout", 64'(timeout), 64'd0);
        count_mode(2'b00, n);
        count_mode(2'b01, n);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 64'({busy, mode, done, pass}), 64'd0);
        done_seen = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Normal run after abort.
        sb.push_back('{pass: 1'b1, timeout: 1'b0, err_bits: 64'd2});
        start_run(64'd1000, 64'd5);
        count_mode(2'b00, n);
        count_mode(2'b01, n);
        finish_test(64'd2);
        check_done("post_abort");

        // test_len=0 finishes on the first TEST cycle.
        sb.push_back('{pass: 1'b1, timeout: 1'b0, err_bits: 64'd0});
        start_run(64'd0, 64'd0);
        count_mode(2'b00, n);
        count_mode(2'b01, n);
        check("len0_align_cycles", 64'(n), 64'd32);
        check("len0_in_test", 64'(mode), 64'd2);
        tick();
        check("len0_immediate_done", 64'(done), 64'd1);
        check_done("len0");

        // Reset in the middle of ALIGN.
        start_run(64'd1000, 64'd0);
        count_mode(2'b00, n);
        repeat (5) tick();
        check("mid_align_mode", 64'(mode), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rst_mid_align");

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
